// File: rtl/adain_norm_lzd.sv
// adain_norm_lzd
//
// Iterative normalisation detector for the AdaIN statistics path. Finds the
// most-significant set bit of the (sign-masked) variance and of the element
// count N. The variance is scanned one CHUNK-bit slice per cycle, starting at
// the top slice. The scan stops at the first nonzero slice, or at slice 0.
// Results are registered and held until the next completion.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; results from the last scan held on outputs
// SCAN  | examining chunk k_q of the captured variance, k_q counts down
//
// Ports:
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   start         : request, sampled only in IDLE
//   n_in          : element count N (WN bits)
//   var_in        : signed variance from the MAC (WIDTH_MAC_IN bits)
//   busy          : scan in progress
//   done          : one-cycle pulse when the results update
//   lead_zero_N   : floor(log2 N), 0 when N == 0
//   lead_zero_var : index of the highest set bit of var_in[WIDTH_MAC_IN-2:0]
//   var_zero      : masked variance was zero
//   var_neg       : sign bit of var_in was set
//   n_zero        : N was zero
module adain_norm_lzd #(
  parameter int N_MAX        = 128,
  parameter int WIDTH_MAC_IN = 48,
  parameter int CHUNK        = 8,
  localparam int WN          = $clog2(N_MAX + 1),
  localparam int WLZN        = $clog2(WN),
  localparam int WLZV        = $clog2(WIDTH_MAC_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WN-1:0]           n_in,
  input  logic [WIDTH_MAC_IN-1:0] var_in,
  output logic                    busy,
  output logic                    done,
  output logic [WLZN-1:0]         lead_zero_N,
  output logic [WLZV-1:0]         lead_zero_var,
  output logic                    var_zero,
  output logic                    var_neg,
  output logic                    n_zero
);

  localparam int NCH = WIDTH_MAC_IN / CHUNK;
  localparam int WK  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WC  = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  generate
    if ((WIDTH_MAC_IN % CHUNK) != 0) begin : g_bad_chunk
      $error("WIDTH_MAC_IN must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [WK-1:0]           k_q, k_d;
  logic [WIDTH_MAC_IN-1:0] var_q, var_d;
  logic                    sign_q, sign_d;
  logic [WN-1:0]           n_q, n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [WLZN-1:0]         lzn_q, lzn_d;
  logic [WLZV-1:0]         lzv_q, lzv_d;
  logic                    var_zero_q, var_zero_d;
  logic                    var_neg_q, var_neg_d;
  logic                    n_zero_q, n_zero_d;

  logic [CHUNK-1:0]        chunk;
  logic                    chunk_nz;
  logic [WC-1:0]           chunk_top;
  logic [WLZV-1:0]         lzv_calc;
  logic [WLZN-1:0]         lzn_calc;

  // Position of the highest set bit in a chunk; 0 for an all-zero chunk.
  function automatic logic [WC-1:0] top_bit(input logic [CHUNK-1:0] c);
    logic [WC-1:0] r;
    r = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (c[i]) r = WC'(i);
    end
    return r;
  endfunction

  // floor(log2 n); 0 for n == 0 (n_zero flags that case separately).
  function automatic logic [WLZN-1:0] floor_log2(input logic [WN-1:0] n);
    logic [WLZN-1:0] r;
    r = '0;
    for (int i = 0; i < WN; i++) begin
      if (n[i]) r = WLZN'(i);
    end
    return r;
  endfunction

  // Chunk currently under examination.
  always_comb begin
    chunk = '0;
    for (int i = 0; i < NCH; i++) begin
      if (k_q == WK'(i)) chunk = var_q[i*CHUNK +: CHUNK];
    end
  end

  assign chunk_nz  = |chunk;
  assign chunk_top = top_bit(chunk);
  assign lzv_calc  = WLZV'(int'(k_q) * CHUNK + int'(chunk_top));
  assign lzn_calc  = floor_log2(n_q);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    var_d      = var_q;
    sign_d     = sign_q;
    n_d        = n_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    lzn_d      = lzn_q;
    lzv_d      = lzv_q;
    var_zero_d = var_zero_q;
    var_neg_d  = var_neg_q;
    n_zero_d   = n_zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Sign bit is masked so the result never exceeds WIDTH_MAC_IN-2.
          var_d   = {1'b0, var_in[WIDTH_MAC_IN-2:0]};
          sign_d  = var_in[WIDTH_MAC_IN-1];
          n_d     = n_in;
          k_d     = WK'(NCH - 1);
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (chunk_nz || (k_q == '0)) begin
          lzv_d      = chunk_nz ? lzv_calc : '0;
          var_zero_d = ~chunk_nz;
          var_neg_d  = sign_q;
          lzn_d      = lzn_calc;
          n_zero_d   = (n_q == '0);
          done_d     = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          k_d = k_q - WK'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      var_q      <= '0;
      sign_q     <= 1'b0;
      n_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lzn_q      <= '0;
      lzv_q      <= '0;
      var_zero_q <= 1'b0;
      var_neg_q  <= 1'b0;
      n_zero_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      var_q      <= var_d;
      sign_q     <= sign_d;
      n_q        <= n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      lzn_q      <= lzn_d;
      lzv_q      <= lzv_d;
      var_zero_q <= var_zero_d;
      var_neg_q  <= var_neg_d;
      n_zero_q   <= n_zero_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign lead_zero_N   = lzn_q;
  assign lead_zero_var = lzv_q;
  assign var_zero      = var_zero_q;
  assign var_neg       = var_neg_q;
  assign n_zero        = n_zero_q;

endmodule

// File: tb/tb_adain_norm_lzd.sv
// Scoreboard bench for adain_norm_lzd: the stimulus process pushes the
// hand-computed expected result of each accepted request; a monitor pops and
// compares whenever done is seen.
module tb_adain_norm_lzd;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  n_in;
  logic [47:0] var_in;
  logic        busy;
  logic        done;
  logic [2:0]  lead_zero_N;
  logic [5:0]  lead_zero_var;
  logic        var_zero;
  logic        var_neg;
  logic        n_zero;

  adain_norm_lzd dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .n_in          (n_in),
    .var_in        (var_in),
    .busy          (busy),
    .done          (done),
    .lead_zero_N   (lead_zero_N),
    .lead_zero_var (lead_zero_var),
    .var_zero      (var_zero),
    .var_neg       (var_neg),
    .n_zero        (n_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] lzv;
    logic [2:0] lzn;
    logic       vz;
    logic       vn;
    logic       nz;
    int         m;
    int         done_cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          if (q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            chk("done_cycle",    cyc, e.done_cyc);
            chk("busy_cycles",   busy_cnt, e.m);
            chk("busy_at_done",  busy, 0);
            chk("lead_zero_var", lead_zero_var, e.lzv);
            chk("lead_zero_N",   lead_zero_N, e.lzn);
            chk("var_zero",      var_zero, e.vz);
            chk("var_neg",       var_neg, e.vn);
            chk("n_zero",        n_zero, e.nz);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Drive one start cycle; returns #1 after E0. Pushes the expectation.
  task automatic send(input logic [47:0] v, input logic [7:0] n, input int m,
                      input logic [5:0] lzv, input logic [2:0] lzn,
                      input logic vz, input logic vn, input logic nz,
                      input bit expect_done);
    exp_t e;
    start  = 1'b1;
    var_in = v;
    n_in   = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (expect_done) begin
      e.lzv = lzv; e.lzn = lzn; e.vz = vz; e.vn = vn; e.nz = nz;
      e.m = m; e.done_cyc = cyc + m;
      q.push_back(e);
    end
  endtask

  task automatic drain(input string name, input int max_cyc);
    int i;
    i = 0;
    while (q.size() != 0 && i < max_cyc) begin
      @(negedge clk);
      #1;
      i++;
    end
    chk(name, q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_lzv"},  lead_zero_var, 0);
    chk({tag, "_lzn"},  lead_zero_N, 0);
    chk({tag, "_flags"}, {var_zero, var_neg, n_zero}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    rst = 1'b1; start = 1'b0; n_in = '0; var_in = '0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fastest path: top chunk nonzero.
    send(48'h4000_0000_0000, 8'd128, 1, 6'd46, 3'd7, 0, 0, 0, 1);
    drain("drain_t1", 20);

    // Mid-word bit in chunk 2.
    send(48'h0000_0001_0000, 8'd100, 4, 6'd16, 3'd6, 0, 0, 0, 1);
    drain("drain_t2", 20);

    // Zero variance, zero N.
    send(48'h0, 8'd0, 6, 6'd0, 3'd0, 1, 0, 1, 1);
    drain("drain_t3a", 20);

    // Sign bit set, masked value 3.
    send(48'h8000_0000_0003, 8'd5, 6, 6'd1, 3'd2, 0, 1, 0, 1);
    drain("drain_t3b", 20);

    // N above N_MAX saturates at 7.
    send(48'h0000_0000_0400, 8'd255, 5, 6'd10, 3'd7, 0, 0, 0, 1);
    drain("drain_nmax", 20);

    // Start while busy is ignored.
    send(48'h0000_0000_0080, 8'd2, 6, 6'd7, 3'd1, 0, 0, 0, 1);
    @(posedge clk);            // E1
    @(negedge clk);
    start  = 1'b1;
    var_in = 48'h4000_0000_0000;
    @(posedge clk);            // E2
    #1;
    start = 1'b0;
    drain("drain_t4", 20);
    repeat (10) @(negedge clk);
    #1;
    chk("t4_hold_lzv",  lead_zero_var, 7);
    chk("t4_hold_done", done, 0);
    chk("t4_no_extra",  q.size(), 0);

    // Mid-scan asynchronous reset of a zero-variance scan.
    @(negedge clk);
    send(48'h0, 8'd9, 6, 6'd0, 3'd0, 1, 0, 0, 0);
    @(posedge clk);            // E1
    @(posedge clk);            // E2
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("rst_no_done_busy", {done, busy}, 0);
    chk_all_zero("post_rst");

    // Back-to-back: second start in the done cycle of the first.
    @(negedge clk);
    send(48'h0000_0000_0001, 8'd1, 6, 6'd0, 3'd0, 0, 0, 0, 1);
    i = 0;
    while (!done && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("b2b_first_done_seen", done, 1);
    send(48'h0000_0100_0000, 8'd3, 3, 6'd24, 3'd1, 0, 0, 0, 1);
    drain("drain_b2b", 20);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adain_norm_lzd.md
# adain_norm_lzd

Iterative normalisation detector for the AdaIN statistics path. After the MAC stage produces the 48-bit variance and the element count N, this block finds the most-significant-set-bit position of each. Its outputs `lead_zero_N` and `lead_zero_var` drive the shift-amount generator directly; they are held stable until the next accepted start.

## Interface

Parameters:
- `N_MAX`, 128: largest element count. N port width is `WN = $clog2(N_MAX+1)` (8).
- `WIDTH_MAC_IN`, 48: variance width, signed two's complement.
- `CHUNK`, 8: bits examined per scan cycle. `WIDTH_MAC_IN` must be a multiple of `CHUNK`. `NCH = WIDTH_MAC_IN/CHUNK` (6).

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request. Sampled only in IDLE.
- `n_in`, input, `WN`: element count.
- `var_in`, input, `WIDTH_MAC_IN`: variance from the MAC.
- `busy`, output, 1: high while SCAN is in progress.
- `done`, output, 1: one-cycle pulse when results update.
- `lead_zero_N`, output, `$clog2(WN)` (3): floor(log2 N).
- `lead_zero_var`, output, `$clog2(WIDTH_MAC_IN)` (6): index of the highest set bit of `var_in[WIDTH_MAC_IN-2:0]`.
- `var_zero`, output, 1: masked variance was zero.
- `var_neg`, output, 1: `var_in` sign bit was set.
- `n_zero`, output, 1: `n_in` was zero.

## Operation

- States: IDLE and SCAN. Reset puts the block in IDLE.
- **IDLE, `start`=1:**
  - Capture `var_in` with the sign bit forced to 0.
  - Capture `var_in[MSB]` into a held sign register.
  - Capture `n_in`.
  - Load chunk index `k = NCH-1`. Assert `busy`. Go to SCAN.
- **IDLE, `start`=0:** hold all outputs.
- **SCAN, each cycle:** examine captured chunk `k`, i.e. bits `[k*CHUNK+CHUNK-1 : k*CHUNK]`.
  - **Chunk nonzero:** at the next edge:
    - `lead_zero_var = k*CHUNK + (priority-encoded top bit within the chunk)`.
    - `var_zero = 0`, `var_neg = sign`.
    - `lead_zero_N = floor(log2 n)`, `n_zero = (n==0)`. When n==0, `lead_zero_N = 0`.
    - `done` pulses, `busy` drops, state returns to IDLE.
  - **Chunk zero and `k>0`:** decrement `k`, stay in SCAN.
  - **Chunk zero and `k==0`:** same update as the nonzero case, except `lead_zero_var = 0` and `var_zero = 1`.
- Because the sign bit is masked, `lead_zero_var` is at most `WIDTH_MAC_IN-2` (46). The downstream `46 - lead_zero_var` therefore never underflows.
- A `start` asserted while in SCAN is ignored, not queued.
- Outputs hold their last result until the next completion.
- n above N_MAX is legal. The result is still floor(log2), saturating naturally at 7 for 8-bit n.
- **Reset at any time:**
  - State goes to IDLE; `busy`, `done`, all flags, `lead_zero_N` and `lead_zero_var` go to 0.
  - The scan in progress is discarded.

## Timing

- Edges are numbered from E0, the edge that samples `start`=1 in IDLE.
- `busy` is 1 from after E0 through the cycle before Em.
- Em is the completion edge, with `m = NCH - j`, where `j` is the chunk holding the highest set bit (m ranges 1..NCH).
- Zero variance gives `m = NCH` (6).
- After Em: outputs are valid and `done`=1 for exactly one cycle; `busy`=0.
- A `start` present in the cycle after Em is accepted (back-to-back allowed).
- Latency is minimum 1 cycle and maximum `NCH` cycles; throughput is one request per m+1 cycles at best.
- All outputs are registered. There are no combinational input-to-output paths.

## Test plan

1. **Fastest path.** var=48'h4000_0000_0000, n=128, start one cycle.
   - done after E1.
   - `lead_zero_var`=46, `lead_zero_N`=7.
   - `var_zero`=0, `var_neg`=0.
2. **Mid-word bit.** var=48'h0000_0001_0000, n=100.
   - done after E4.
   - `lead_zero_var`=16, `lead_zero_N`=6.
   - `busy` high for exactly 4 cycles.
3. **Zero and sign.**
   - var=0, n=0: done after E6; `var_zero`=1, `lead_zero_var`=0, `n_zero`=1, `lead_zero_N`=0.
   - Then var=48'h8000_0000_0003: done after E6; `lead_zero_var`=1, `var_neg`=1.
4. **Start while busy.** Start var=48'h0000_0000_0080. Pulse start again at E2 with var=48'h4000_0000_0000.
   - Second start is ignored.
   - done after E6 with `lead_zero_var`=7.
   - Outputs hold, with no further done.
5. **Mid-scan reset, then back-to-back.**
   - Assert rst asynchronously between E2 and E3 of a zero-variance scan: all outputs go to 0 immediately and no done follows.
   - After release, start var=1, n=1: done after E6; `lead_zero_var`=0, `lead_zero_N`=0, `var_zero`=0.
   - Start again in the done cycle with var=48'h0000_0100_0000: accepted, done after E3, `lead_zero_var`=24.
